// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default line timing and the
// command bytes recognised by the downstream command decoder.
package uart_pkg;

    localparam int unsigned UART_CLK_HZ     = 12000000;
    localparam int unsigned UART_BAUD       = 9600;
    localparam int unsigned UART_OVERSAMPLE = 16;

    localparam logic [7:0] CMD_TRIG = 8'h53;
    localparam logic [7:0] CMD_VEC  = 8'h5C;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    // Clocks per oversampling tick.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Divide-by-DIV tick generator. A synchronous clear restarts the count so the
// following ticks are phase-aligned to the clearing event.
module uart_baud_tick #(
    parameter int unsigned DIV = 78
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises and oversamples rx, frames characters by
// majority vote around mid-bit and presents each byte on a valid/ready port.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = UART_CLK_HZ,
    parameter int unsigned BAUD       = UART_BAUD,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);

    // Vote window sits on the three samples around mid-bit.
    localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    logic rx_meta;
    logic rxs;
    logic rxs_prev;

    rx_state_e    state_q, state_d;
    logic [SW-1:0] samp_q, samp_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          v_lo_q, v_lo_d;
    logic          v_mid_q, v_mid_d;

    logic tick;
    logic tick_clear;
    logic vote;
    logic sample_hi;
    logic sample_last;
    logic byte_done;
    logic frame_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clear),
        .tick  (tick)
    );

    assign vote        = (v_lo_q & v_mid_q) | (v_lo_q & rxs) | (v_mid_q & rxs);
    assign sample_hi   = tick && (samp_q == S_HI);
    assign sample_last = tick && (samp_q == S_LAST);
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        samp_d     = samp_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        v_lo_d     = v_lo_q;
        v_mid_d    = v_mid_q;
        tick_clear = 1'b0;
        byte_done  = 1'b0;
        frame_bad  = 1'b0;

        if (tick && (state_q == START || state_q == DATA || state_q == STOP)) begin
            samp_d = (samp_q == S_LAST) ? '0 : samp_q + 1'b1;
            if (samp_q == S_LO) begin
                v_lo_d = rxs;
            end
            if (samp_q == S_MID) begin
                v_mid_d = rxs;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (rxs_prev && !rxs) begin
                    state_d    = START;
                    samp_d     = '0;
                    bit_d      = '0;
                    tick_clear = 1'b1;
                end
            end
            START: begin
                if (sample_hi && vote) begin
                    state_d = IDLE;
                end else if (sample_last) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample_hi) begin
                    shift_d = {vote, shift_q[7:1]};
                end
                if (sample_last) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop so a start edge at the end of the stop bit is seen.
                if (sample_hi) begin
                    if (vote) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            v_lo_q  <= 1'b1;
            v_mid_q <= 1'b1;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            v_lo_q  <= v_lo_d;
            v_mid_q <= v_mid_d;
        end
    end

    // A byte finishing while the consumer accepts the previous one still loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= 1'b0;
            if (byte_done) begin
                if (!out_valid || out_ready) begin
                    out_data  <= shift_q;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
